// File: rtl/eeprom_i2c_pkg.sv
// eeprom_i2c_pkg: shared state encoding and default device address for the I2C EEPROM target
package eeprom_i2c_pkg;
   localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b1010000;
   typedef enum logic [3:0] {
      IDLE,
      DEVADDR,
      ACK_DEV,
      WADDR,
      ACK_WADDR,
      WDATA,
      ACK_WDATA,
      RDATA,
      MACK,
      WAIT_STOP
   } state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-flop SCL/SDA synchronizers plus SCL edge and START/STOP detection
//   clk, rst           : system clock, synchronous active-high reset
//   scl, sda           : raw bus lines
//   sda_s              : synchronized SDA level
//   scl_rise, scl_fall : one-clk SCL edge strobes
//   start, stop        : one-clk bus condition strobes
module i2c_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);
   logic [2:0] scl_q, sda_q;
   always_ff @(posedge clk)
      if (rst) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[1:0], scl};
         sda_q <= {sda_q[1:0], sda};
      end
   assign sda_s    = sda_q[1];
   assign scl_rise = scl_q[1] & ~scl_q[2];
   assign scl_fall = ~scl_q[1] & scl_q[2];
   assign start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
   assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
endmodule

// File: rtl/eeprom_i2c_slave.sv
// eeprom_i2c_slave: I2C EEPROM target with page-wrapping writes and sequential reads
//   clk, rst          : system clock, synchronous active-high reset
//   wp                : write protect, present only with EEPROM_I2C_SLAVE_WP_EN
//   SCL, SDA          : I2C bus, SDA open-drain
//   busy              : transaction addressed to this target in progress
//   wr_pulse, wr_addr : byte-commit strobe and its address
module eeprom_i2c_slave import eeprom_i2c_pkg::*; #(
   parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
   parameter int         MEM_AW    = 8,
   parameter int         PAGE_SIZE = 8
) (
   input  logic              clk,
   input  logic              rst,
`ifdef EEPROM_I2C_SLAVE_WP_EN
   input  logic              wp,
`endif
   input  logic              SCL,
   inout  wire               SDA,
   output logic              busy,
   output logic              wr_pulse,
   output logic [MEM_AW-1:0] wr_addr
);
   localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'(PAGE_SIZE - 1);
   logic [7:0] mem [2**MEM_AW];
   state_t state;
   logic [2:0] bit_cnt;
   logic [7:0] shreg, byte_in;
   logic [MEM_AW-1:0] ptr;
   logic ack_phase, sda_oe, wp_on, mem_we, sda_s, scl_rise, scl_fall, start, stop;
`ifdef EEPROM_I2C_SLAVE_WP_EN
   assign wp_on = wp;
`else
   assign wp_on = 1'b0;
`endif
   i2c_line_sync u_sync (
      .clk(clk),
      .rst(rst),
      .scl(SCL),
      .sda(SDA),
      .sda_s(sda_s),
      .scl_rise(scl_rise),
      .scl_fall(scl_fall),
      .start(start),
      .stop(stop)
   );
   assign SDA     = sda_oe ? 1'b0 : 1'bz;
   assign byte_in = {shreg[6:0], sda_s};
   // commit only on the falling edge that opens the data ACK slot
   assign mem_we  = !rst && state == ACK_WDATA && scl_fall && !ack_phase;
   always_ff @(posedge clk)
      if (mem_we) mem[ptr] <= shreg;
   always_ff @(posedge clk)
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         ptr       <= '0;
         ack_phase <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_pulse  <= 1'b0;
         wr_addr   <= '0;
      end else begin
         wr_pulse <= 1'b0;
         if (start) begin
            state     <= DEVADDR;
            bit_cnt   <= '0;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
         end else if (stop) begin
            state     <= IDLE;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
         end else case (state)
            DEVADDR, WADDR, WDATA: if (scl_rise) begin
               shreg   <= byte_in;
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) begin
                  if ((state == DEVADDR && byte_in[7:1] != DEV_ADDR) || (state == WDATA && wp_on)) begin
                     state <= WAIT_STOP;
                     busy  <= 1'b0;
                  end else begin
                     state <= state == DEVADDR ? ACK_DEV : state == WADDR ? ACK_WADDR : ACK_WDATA;
                     busy  <= 1'b1;
                  end
               end
            end
            // phase 0: first falling edge pulls SDA low; phase 1: next falling edge releases it
            ACK_DEV, ACK_WADDR, ACK_WDATA: if (scl_fall) begin
               ack_phase <= ~ack_phase;
               sda_oe    <= ~ack_phase;
               if (!ack_phase) begin
                  if (state == ACK_WADDR) ptr <= shreg[MEM_AW-1:0];
                  if (state == ACK_WDATA) begin
                     wr_pulse <= 1'b1;
                     wr_addr  <= ptr;
                     ptr      <= (ptr & ~PAGE_MASK) | ((ptr + 1'b1) & PAGE_MASK);
                  end
               end else begin
                  bit_cnt <= '0;
                  state   <= state != ACK_DEV ? WDATA : shreg[0] ? RDATA : WADDR;
                  if (state == ACK_DEV && shreg[0]) begin
                     shreg  <= mem[ptr];
                     sda_oe <= ~mem[ptr][7];
                  end
               end
            end
            // ack_phase here flags that the next byte must be loaded on the coming fall
            RDATA: if (scl_fall) begin
               ack_phase <= 1'b0;
               shreg     <= ack_phase ? mem[ptr] : {shreg[6:0], 1'b0};
               sda_oe    <= ack_phase ? ~mem[ptr][7] : ~shreg[6];
            end else if (scl_rise) begin
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) begin
                  state <= MACK;
                  ptr   <= ptr + 1'b1;
               end
            end
            MACK: if (scl_fall) sda_oe <= 1'b0;
            else if (scl_rise) begin
               if (sda_s) begin
                  state <= WAIT_STOP;
                  busy  <= 1'b0;
               end else begin
                  state     <= RDATA;
                  ack_phase <= 1'b1;
                  bit_cnt   <= '0;
               end
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// tb_eeprom_i2c_slave: randomized I2C master with array memory model and queued scoreboard
`timescale 1ns/1ps
module tb_eeprom_i2c_slave;
   localparam int Q = 6;
   logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
`ifdef EEPROM_I2C_SLAVE_WP_EN
   logic wp = 1'b0;
`endif
   wire sda_bus;
   logic busy, wr_pulse;
   logic [7:0] wr_addr;
   int vectors = 0, miscompares = 0;
   int model_mem [256];
   int tx_data[$];
   int exp_wr[$], exp_v[$], obs_v[$];
   string exp_n[$];
   int e_wr, e_val, o_val;
   string e_name;
   always #5 clk = ~clk;
   assign sda_bus = sda_m ? 1'bz : 1'b0;
   pullup (sda_bus);
   eeprom_i2c_slave dut (
      .clk(clk),
      .rst(rst),
`ifdef EEPROM_I2C_SLAVE_WP_EN
      .wp(wp),
`endif
      .SCL(scl_m),
      .SDA(sda_bus),
      .busy(busy),
      .wr_pulse(wr_pulse),
      .wr_addr(wr_addr)
   );
   always @(negedge clk) begin
      if (wr_pulse) begin
         vectors++;
         if (exp_wr.size() == 0) begin
            miscompares++;
            $display("FAIL wr_pulse_unexpected: wr_addr=%0h, required no write", wr_addr);
         end else begin
            e_wr = exp_wr.pop_front();
            if (int'(wr_addr) != e_wr) begin
               miscompares++;
               $display("FAIL wr_addr: got %0h, required %0h", wr_addr, e_wr);
            end
         end
      end
      if (obs_v.size() > 0) begin
         vectors++;
         e_name = exp_n.pop_front();
         e_val  = exp_v.pop_front();
         o_val  = obs_v.pop_front();
         if (o_val != e_val) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", e_name, o_val, e_val);
         end
      end
   end
   task automatic check(input string name, input int act, input int exp);
      exp_n.push_back(name);
      exp_v.push_back(exp);
      obs_v.push_back(act);
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic i2c_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask
   task automatic i2c_stop();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask
   task automatic bit_io(input logic b, output logic r);
      sda_m = b; tick(Q);
      scl_m = 1'b1; tick(Q);
      r = sda_bus; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask
   task automatic send_byte(input logic [7:0] d, input int exp_ack, input string name);
      logic r;
      for (int i = 7; i >= 0; i--) bit_io(d[i], r);
      bit_io(1'b1, r);
      check(name, int'(!r), exp_ack);
   endtask
   task automatic recv_byte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_io(1'b1, r);
         d[i] = r;
      end
      bit_io(nack, r);
   endtask
   // page write: byte i lands at the page base plus (offset + i) modulo the page size
   task automatic wr_tx(input int addr);
      int a;
      i2c_start();
      send_byte(8'hA0, 1, "wr_ack_dev");
      check("busy_in_write", int'(busy), 1);
      send_byte(8'(addr), 1, "wr_ack_waddr");
      for (int i = 0; i < tx_data.size(); i++) begin
         a = addr / 8 * 8 + (addr % 8 + i) % 8;
         model_mem[a] = tx_data[i];
         exp_wr.push_back(a);
         send_byte(8'(tx_data[i]), 1, "wr_ack_wdata");
      end
      i2c_stop();
      check("busy_after_write", int'(busy), 0);
   endtask
   // random read: set pointer, repeated START, sequential read with full-range wrap
   task automatic rd_tx(input int addr, input int n);
      logic [7:0] d;
      int a;
      i2c_start();
      send_byte(8'hA0, 1, "rd_ack_dev_w");
      send_byte(8'(addr), 1, "rd_ack_waddr");
      i2c_start();
      send_byte(8'hA1, 1, "rd_ack_dev_r");
      check("busy_in_read", int'(busy), 1);
      for (int i = 0; i < n; i++) begin
         recv_byte(i == n - 1, d);
         a = (addr + i) % 256;
         if (model_mem[a] >= 0) check($sformatf("rd_data_%02h", a), int'(d), model_mem[a]);
      end
      check("sda_released_after_nack", int'(sda_bus), 1);
      check("busy_after_nack", int'(busy), 0);
      i2c_stop();
   endtask
   initial begin
      logic r;
      int addr;
      foreach (model_mem[i]) model_mem[i] = -1;
      tick(4);
      check("rst_busy", int'(busy), 0);
      check("rst_wr_pulse", int'(wr_pulse), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_sda", int'(sda_bus), 1);
      rst = 1'b0;
      tick(4);
      tx_data = {'h55, 'hAA};
      wr_tx('h10);
      check("wr_addr_last", int'(wr_addr), 'h11);
      rd_tx('h10, 2);
      i2c_start();
      send_byte(8'hA4, 0, "nack_dev_a4");
      check("busy_a4", int'(busy), 0);
      send_byte(8'h10, 0, "nack_wait_stop");
      i2c_stop();
      check("busy_a4_stop", int'(busy), 0);
      tx_data = {'h5A};
      wr_tx('h08);
      tx_data = {};
      for (int i = 0; i < 10; i++) tx_data.push_back(int'($urandom_range(0, 255)));
      wr_tx('h06);
      rd_tx('h00, 9);
      i2c_start();
      send_byte(8'hA0, 1, "rst_ack_dev");
      send_byte(8'h30, 1, "rst_ack_waddr");
      for (int i = 0; i < 4; i++) bit_io(1'b0, r);
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(2);
      rst = 1'b1; tick(2);
      check("midrst_busy", int'(busy), 0);
      check("midrst_sda", int'(sda_bus), 1);
      check("midrst_wr_addr", int'(wr_addr), 0);
      rst = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
      i2c_stop();
      tx_data = {'hC3, 'h3C};
      wr_tx('h30);
      rd_tx('h30, 2);
`ifdef EEPROM_I2C_SLAVE_WP_EN
      tx_data = {'h77};
      wr_tx('h20);
      wp = 1'b1;
      i2c_start();
      send_byte(8'hA0, 1, "wp_ack_dev");
      send_byte(8'h20, 1, "wp_ack_waddr");
      send_byte(8'h33, 0, "wp_nack_wdata");
      check("wp_busy", int'(busy), 0);
      i2c_stop();
      wp = 1'b0;
      rd_tx('h20, 1);
`endif
      for (int t = 0; t < 5; t++) begin
         addr = int'($urandom_range(0, 255));
         tx_data = {};
         for (int i = int'($urandom_range(1, 8)); i > 0; i--) tx_data.push_back(int'($urandom_range(0, 255)));
         wr_tx(addr);
         rd_tx(addr / 8 * 8, 8);
      end
      tick(40);
      check("wr_pending", exp_wr.size(), 0);
      tick(40);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
